ccsds_asm_framer: RTL and testbench

Downstream stage of the CCSDS LDPC encoder. It takes each encoded codeblock as a byte stream and emits it as a channel access data unit (CADU): a 32-bit attached sync marker (ASM), then the codeblock bytes, with optional CCSDS pseudo-randomization. Both sides use AXI4-Stream with backpressure. The output feeds the modulator/serializer interface.

---
 rtl/ccsds_asm_framer.sv | 153 +++++++++++++++
 tb/tb_ccsds_asm_framer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ccsds_asm_framer.sv
// ccsds_asm_framer: wraps each encoded codeblock into a CADU.
// A CADU is the 32-bit attached sync marker, sent MSB byte first,
// followed by BLOCK_BYTES codeblock bytes. Both sides are AXI4-Stream.
//
// Optional feature: define CCSDS_RANDOMIZER_EN to XOR the data bytes with
// the CCSDS pseudo-random sequence h(x)=x^8+x^7+x^5+x^3+1, seeded all ones.
// The ASM bytes are never randomized.
//
// Framing always follows the internal byte count. s_axis_tlast is only
// compared against that count, and a disagreement produces a one-cycle
// len_err pulse.
module ccsds_asm_framer #(
  parameter int          width       = 8,
  parameter int          BLOCK_BYTES = 160,
  parameter logic [31:0] ASM         = 32'h1ACFFC1D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [width-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic             len_err
);

  localparam int ASM_BYTES = 32 / width;
  localparam int AW        = $clog2(ASM_BYTES);
  localparam int CW        = (BLOCK_BYTES > 2) ? $clog2(BLOCK_BYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ASM, S_DATA} state_t;

  state_t           state_q;
  logic [AW-1:0]    asm_cnt_q;
  logic [CW-1:0]    cnt_q;
  logic [width-1:0] tdata_q;
  logic             tvalid_q;
  logic             tlast_q;
  logic             len_err_q;

  logic             load;
  logic             accept;
  logic             cnt_last;
  logic [width-1:0] data_out;
  logic [width-1:0] asm_lut [ASM_BYTES];

  // Marker bytes in transmit order. Entry 0 is the most significant byte.
  for (genvar gi = 0; gi < ASM_BYTES; gi++) begin : g_asm_lut
    assign asm_lut[gi] = ASM[width*(ASM_BYTES-1-gi) +: width];
  end

  // The output register may take a new byte when it is empty or being drained.
  assign load          = !tvalid_q || m_axis_tready;
  assign s_axis_tready = (state_q == S_DATA) && load;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign cnt_last      = (cnt_q == CW'(BLOCK_BYTES - 1));

`ifdef CCSDS_RANDOMIZER_EN
  // lfsr_q holds the next 8 sequence bits. Bit 7 is the earliest bit and
  // lines up with data bit 7, the first channel bit.
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Advance the sequence window by 8 bits:
  // a[n+8] = a[n+7] ^ a[n+5] ^ a[n+3] ^ a[n].
  always_comb begin
    lfsr_d = lfsr_q;
    for (int i = 0; i < 8; i++) begin
      lfsr_d = {lfsr_d[6:0], lfsr_d[0] ^ lfsr_d[2] ^ lfsr_d[4] ^ lfsr_d[7]};
    end
  end

  // Reseed to all ones during the marker, and step once per accepted data byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 8'hFF;
    end else if (state_q == S_ASM) begin
      lfsr_q <= 8'hFF;
    end else if (accept) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign data_out = s_axis_tdata ^ lfsr_q;
`else
  assign data_out = s_axis_tdata;
`endif

  // Framing FSM. It also drives the registered output stage and the length check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      asm_cnt_q <= '0;
      cnt_q     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // The previous CADU's last byte may still be draining here.
          if (load) begin
            tvalid_q <= 1'b0;
          end
          // The first input byte only announces a block. It is not consumed here.
          if (s_axis_tvalid) begin
            state_q   <= S_ASM;
            asm_cnt_q <= '0;
          end
        end
        S_ASM: begin
          if (load) begin
            tdata_q   <= asm_lut[asm_cnt_q];
            tvalid_q  <= 1'b1;
            tlast_q   <= 1'b0;
            asm_cnt_q <= asm_cnt_q + AW'(1);
            if (asm_cnt_q == AW'(ASM_BYTES - 1)) begin
              state_q <= S_DATA;
              cnt_q   <= '0;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            tdata_q   <= data_out;
            tvalid_q  <= 1'b1;
            tlast_q   <= cnt_last;
            len_err_q <= (s_axis_tlast != cnt_last);
            if (cnt_last) begin
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else if (load) begin
            tvalid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign len_err       = len_err_q;

endmodule

// File: tb/tb_ccsds_asm_framer.sv
// Testbench for ccsds_asm_framer, built as a scoreboard.
// The driver pushes each expected CADU into a queue. A monitor pops that
// queue and compares every output byte as it transfers.
// Compile with CCSDS_RANDOMIZER_EN defined to test the randomizer build.
module tb_ccsds_asm_framer;

  localparam int BB = 160;
`ifdef CCSDS_RANDOMIZER_EN
  localparam bit RAND = 1'b1;
`else
  localparam bit RAND = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       m_axis_tready;
  logic       len_err;

  ccsds_asm_framer #(.width(8), .BLOCK_BYTES(BB), .ASM(32'h1ACFFC1D)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       first;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  int         lerr_seen = 0;
  int         exp_lerr = 0;
  bit         ready_rand = 1'b0;
  bit         period_en = 1'b0;
  bit         prev_start_valid = 1'b0;
  int         prev_start = 0;
  bit         stall_prev = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last;
  bit         pn_bits [BB*8];
  logic [7:0] pn_tab [8] = '{8'hFF, 8'h48, 8'h0E, 8'hC0, 8'h9A, 8'h0D, 8'h70, 8'hBC};
  logic [7:0] asm_bytes [4] = '{8'h1A, 8'hCF, 8'hFC, 8'h1D};
  logic [7:0] cur_blk [BB];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, got, want);
  endtask

  // Reference sequence from the recurrence a[n+8] = a[n+7]^a[n+5]^a[n+3]^a[n], with a[0..7] = 1.
  function automatic logic [7:0] pn_byte(input int k);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[7-j] = pn_bits[8*k + j];
    return b;
  endfunction

  always @(posedge clk) cyc++;

  // Downstream ready: always 1, or a 50% random pattern.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: compares each transferring byte, checks stall stability, counts len_err pulses.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      prev_start_valid = 1'b0;
    end else begin
      if (len_err) lerr_seen++;
      if (stall_prev)
        chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, hold_last, hold_data});
      if (m_axis_tvalid && !m_axis_tready)
        chk("stall_s_tready", {31'd0, s_axis_tready}, 32'd0);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_byte: got %0h, required no output", m_axis_tdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("cadu_data", {24'd0, m_axis_tdata}, {24'd0, e.data});
          chk("cadu_last", {31'd0, m_axis_tlast}, {31'd0, e.last});
          if (e.first) begin
            if (period_en && prev_start_valid) chk("cadu_period", cyc - prev_start, BB + 5);
            prev_start = cyc;
            prev_start_valid = 1'b1;
          end
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      hold_data = m_axis_tdata;
      hold_last = m_axis_tlast;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic tl, input int gap);
    bit done;
    done = 1'b0;
    if (gap > 0) begin
      s_axis_tvalid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    s_axis_tdata = d;
    s_axis_tlast = tl;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      done = s_axis_tready;
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      $display("FAIL send_timeout: byte %0h not accepted, s_axis_tready=0, required 1", d);
    end
  endtask

  // Pushes the expected CADU, then drives cur_blk. The block stops before byte stop_at when stop_at >= 0.
  task automatic send_block(input int gap_max, input int bad_at, input bit omit_last,
                            input bit use_tab, input int stop_at);
    for (int i = 0; i < 4; i++) exp_q.push_back('{asm_bytes[i], 1'b0, (i == 0)});
    for (int i = 0; i < BB; i++) begin
      logic [7:0] ed;
      ed = cur_blk[i];
      if (RAND) ed = (use_tab && i < 8) ? (cur_blk[i] ^ pn_tab[i]) : (cur_blk[i] ^ pn_byte(i));
      exp_q.push_back('{ed, (i == BB-1), 1'b0});
    end
    for (int i = 0; i < BB; i++) begin
      logic tl;
      int   gap;
      if (i == stop_at) return;
      tl  = ((i == BB-1) && !omit_last) || (i == bad_at);
      if (tl != (i == BB-1)) exp_lerr++;
      gap = (gap_max > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, gap_max) : 0;
      send_byte(cur_blk[i], tl, gap);
    end
    s_axis_tvalid = 1'b0;
    $display("block sent: %0d bytes, bad_at=%0d omit_last=%0d, %0d checks so far", BB, bad_at, omit_last, checks);
  endtask

  task automatic fill_random();
    for (int i = 0; i < BB; i++) cur_blk[i] = 8'($urandom);
  endtask

  task automatic drain(input string name);
    int c;
    s_axis_tvalid = 1'b0;
    c = 0;
    while (exp_q.size() != 0 && c < 5000) begin @(posedge clk); c++; end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d bytes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    chk(name, lerr_seen, exp_lerr);
  endtask

  initial begin
    for (int n = 0; n < 8; n++) pn_bits[n] = 1'b1;
    for (int n = 8; n < BB*8; n++)
      pn_bits[n] = pn_bits[n-1] ^ pn_bits[n-3] ^ pn_bits[n-5] ^ pn_bits[n-8];

    rst = 1'b1;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    #1;
    chk("reset_outputs", {23'd0, m_axis_tvalid, m_axis_tlast, s_axis_tready, len_err, m_axis_tdata}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back blocks with ready held high: period must be BB+5.
    period_en = 1'b1;
    for (int b = 0; b < 3; b++) begin fill_random(); send_block(0, -1, 1'b0, 1'b0, -1); end
    drain("len_err_clean");
    period_en = 1'b0;

    // Zero blocks: the output shows the bare PN sequence when the randomizer is on.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < BB; i++) cur_blk[i] = 8'h00;
      send_block(0, -1, 1'b0, 1'b1, -1);
    end
    drain("len_err_zero");

    // Random downstream stalls and input gaps.
    ready_rand = 1'b1;
    for (int b = 0; b < 10; b++) begin fill_random(); send_block(3, -1, 1'b0, 1'b0, -1); end
    drain("len_err_random");
    ready_rand = 1'b0;

    // Early tlast on byte 100, then a missing tlast on byte 160.
    fill_random(); send_block(0, 99, 1'b0, 1'b0, -1);
    drain("len_err_early");
    fill_random(); send_block(0, -1, 1'b1, 1'b0, -1);
    drain("len_err_missing");

    // Reset during data byte 50. The next block must start cleanly.
    fill_random(); send_block(0, -1, 1'b0, 1'b0, 50);
    #2 rst = 1'b1;
    s_axis_tvalid = 1'b0;
    #1;
    chk("midblock_reset", {23'd0, m_axis_tvalid, m_axis_tlast, s_axis_tready, len_err, m_axis_tdata}, 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    fill_random(); send_block(0, -1, 1'b0, 1'b0, -1);
    drain("len_err_after_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
